recip_div_arbiter: RTL and testbench
====================================

Name: recip_div_arbiter

Overview:
Shares one reciprocal divider instance (AXI-Stream, 64-bit divisor/dividend, 88-bit quotient output, tuser = divide-by-zero) between N_REQ triangle-setup requesters. It picks among requesters by round-robin and issues each granted divisor with a fixed dividend of 1.0 (Q0.16). It records each issuing requester in an in-order tag FIFO, then routes each divider result back to the requester that issued it. The block sits between the setup units and the divider, so several setup engines can run without each owning a divider.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_OUT, 8, max outstanding divides (tag FIFO depth, power of 2); must be at least the divider latency for full throughput
DIVIDEND, 64'd65536, constant dividend driven on every issue (1.0 in Q0.16)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester divide request
req_ready  out  N_REQ  one-hot accept; transfer when req_valid[i]&&req_ready[i]
req_divisor  in  N_REQ*64  packed; slice i = |denominator| of requester i
rsp_valid  out  N_REQ  one-hot, one-cycle result pulse; no back-pressure
rsp_recip  out  17  reciprocal {quotient[15:0],1'b0}; shared by all requesters, qualified by rsp_valid
rsp_dbz  out  1  divide-by-zero flag of the current result
div_s_valid  out  1  to divider divisor and dividend tvalid (tied together)
div_s_ready  in  1  divider divisor tready
div_divisor  out  64  divisor tdata
div_dividend  out  64  dividend tdata = DIVIDEND
div_m_valid  in  1  divider dout tvalid; divider m_tready is tied 1 externally
div_m_data  in  88  divider dout tdata
div_dbz  in  1  divider dout tuser
outstanding  out  clog2(MAX_OUT)+1  number of issued, unreturned divides
busy  out  1  outstanding!=0 || any req_valid
err_orphan  out  1  sticky: result arrived while tag FIFO empty

Behaviour:
- Reset (rst_n low, asynchronous):
  - req_ready, rsp_valid, rsp_recip, rsp_dbz, div_s_valid, outstanding and err_orphan go to 0.
  - The round-robin pointer goes to 0 and the tag FIFO is emptied.
- Reset mid-operation: all in-flight tags are discarded. The divider shares rst_n, so its in-flight results are flushed too. No rsp_valid is produced for any request issued before reset.
- space = (outstanding < MAX_OUT) || tag_pop. Popping and pushing in the same cycle while the FIFO is full is legal.
- Grant (combinational):
  - The grant is the first i with req_valid[i], scanning from rr_ptr upward with wrap-around.
  - div_s_valid = any(req_valid) && space.
  - div_divisor = req_divisor slice of the grant, or 0 when idle.
  - req_ready[grant] = div_s_ready && space; every other req_ready bit is 0.
  - Issue latency is zero cycles: the request transfers in the same cycle as the divider handshake.
- On a transfer:
  - Push the grant index into the tag FIFO.
  - rr_ptr <= (grant+1) mod N_REQ.
  - If there is no transfer, rr_ptr holds.
- Requester obligation: hold req_valid and req_divisor stable until accepted. The arbiter never drops a pending valid, and grant is recomputed every cycle.
- Fairness: with all requesters valid, grants rotate 0,1,...,N_REQ-1,0,...; no requester waits more than N_REQ-1 transfers.
- On div_m_valid:
  - Pop the FIFO head, giving tag t.
  - Next cycle: rsp_valid[t]=1, rsp_recip={div_m_data[15:0],1'b0}, rsp_dbz=div_dbz.
  - Response latency is one register stage after div_m_valid, and results return in issue order.
- Orphan result: if div_m_valid arrives with the FIFO empty and no same-cycle push, there is no pop and no rsp_valid, and err_orphan is set. err_orphan clears only on reset.
- outstanding counter:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Never exceeds MAX_OUT and never underflows.
- rsp_recip and rsp_dbz hold their last value when rsp_valid is 0.
- FIFO pointers wrap modulo MAX_OUT.

Test Plan:
1. Single request: requester 1 issues divisor 4 with div_s_ready=1. Expect req_ready=0010 in the same cycle and the divider returns quotient 16384. Expect rsp_valid=0010 for one cycle and rsp_recip=32768, one cycle after div_m_valid.
2. Round-robin: all 4 requesters valid continuously with divisor=i+1. Expect grant order 0,1,2,3,0,1. Each rsp_valid goes to the matching requester, with rsp_recip = {65536/(i+1) low 16 bits, 0}.
3. Back-pressure: div_s_ready=0 for 5 cycles while requesters 0 and 2 are valid. Expect req_ready=0000 and rr_ptr unchanged; on release, requester 0 is accepted before requester 2.
4. FIFO full: MAX_OUT=8, divider stalled with no output, continuous requests. Expect exactly 8 transfers, outstanding=8 and div_s_valid=0. When one result returns, accept one request in the same cycle and outstanding stays 8.
5. Divide by zero and orphan: requester 3 issues divisor 0 and the divider returns tuser=1; expect rsp_dbz=1 with rsp_valid=1000. Then inject div_m_valid with an empty FIFO; expect no rsp_valid and err_orphan=1 held.
6. Reset mid-flight: 3 divides outstanding, pulse rst_n low asynchronously between clock edges. Expect outputs 0 immediately and outstanding=0. Expect no rsp_valid afterwards for the pre-reset requests, and the next grant goes to requester 0.

Source files
------------

// File: rtl/recip_div_arbiter_if.sv
// Signal bundle between the triangle-setup requesters, the arbiter and the shared reciprocal divider.
interface recip_div_arbiter_if #(
   parameter int N_REQ   = 4,
   parameter int MAX_OUT = 8
);
   localparam int OW = $clog2(MAX_OUT) + 1;

   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ*64-1:0] req_divisor;
   logic [N_REQ-1:0]    rsp_valid;
   logic [16:0]         rsp_recip;
   logic                rsp_dbz;
   logic                div_s_valid;
   logic                div_s_ready;
   logic [63:0]         div_divisor;
   logic [63:0]         div_dividend;
   logic                div_m_valid;
   logic [87:0]         div_m_data;
   logic                div_dbz;
   logic [OW-1:0]       outstanding;
   logic                busy;
   logic                err_orphan;

   modport slave (
      input  req_valid, req_divisor, div_s_ready, div_m_valid, div_m_data, div_dbz,
      output req_ready, rsp_valid, rsp_recip, rsp_dbz, div_s_valid, div_divisor,
             div_dividend, outstanding, busy, err_orphan
   );

   modport master (
      output req_valid, req_divisor, div_s_ready, div_m_valid, div_m_data, div_dbz,
      input  req_ready, rsp_valid, rsp_recip, rsp_dbz, div_s_valid, div_divisor,
             div_dividend, outstanding, busy, err_orphan
   );
endinterface

// File: rtl/recip_div_arbiter.sv
// Round-robin sharing of one reciprocal divider between N_REQ setup units; an in-order
// tag FIFO routes each divider result back to the requester that issued it.
module recip_div_arbiter #(
   parameter int          N_REQ    = 4,
   parameter int          MAX_OUT  = 8,
   parameter logic [63:0] DIVIDEND = 64'd65536
) (
   input  logic              clk,
   input  logic              rst_n,
   recip_div_arbiter_if.slave bus
);
   localparam int TW = $clog2(N_REQ);
   localparam int PW = $clog2(MAX_OUT);
   localparam int OW = PW + 1;
   localparam logic [TW:0]   C_NREQ = (TW+1)'(N_REQ);
   localparam logic [TW-1:0] C_LAST = TW'(N_REQ - 1);
   localparam logic [OW-1:0] C_MAX  = OW'(MAX_OUT);

   logic [TW-1:0]    r_rr_ptr;
   logic [TW-1:0]    r_tag_mem [MAX_OUT];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [OW-1:0]    r_outstanding;
   logic [N_REQ-1:0] r_rsp_valid;
   logic [16:0]      r_rsp_recip;
   logic             r_rsp_dbz;
   logic             r_err_orphan;

   logic [2*N_REQ-1:0] w_dbl;
   logic [2*N_REQ-1:0] w_dbl_sh;
   logic [N_REQ-1:0]   w_rot;
   logic [TW-1:0]      w_off;
   logic [TW:0]        w_sum;
   logic [TW-1:0]      w_grant;
   logic [TW-1:0]      w_pop_tag;
   logic [N_REQ-1:0]   w_tag_oh;
   logic [63:0]        w_div_arr [N_REQ];
   logic               w_any;
   logic               w_empty;
   logic               w_space;
   logic               w_s_valid;
   logic               w_push;
   logic               w_pop;
   logic               w_bypass;
   logic               w_fifo_wr;
   logic               w_fifo_rd;
   logic               w_unused;

   // Rotate the request vector so bit 0 is the requester at rr_ptr, then pick the lowest set bit.
   assign w_dbl    = {bus.req_valid, bus.req_valid};
   assign w_dbl_sh = w_dbl >> r_rr_ptr;
   assign w_rot    = w_dbl_sh[N_REQ-1:0];

   always_comb begin
      w_off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = TW'(k);
         end
      end
   end

   assign w_sum   = {1'b0, r_rr_ptr} + {1'b0, w_off};
   assign w_grant = (w_sum >= C_NREQ) ? TW'(w_sum - C_NREQ) : TW'(w_sum);

   assign w_any   = |bus.req_valid;
   assign w_empty = (r_outstanding == '0);
   // A full FIFO still accepts when a result pops the head in the same cycle.
   assign w_space   = (r_outstanding < C_MAX) || (bus.div_m_valid && !w_empty);
   assign w_s_valid = rst_n && w_any && w_space;
   assign w_push    = w_s_valid && bus.div_s_ready;
   assign w_pop     = bus.div_m_valid && (!w_empty || w_push);
   assign w_bypass  = w_empty && w_push && w_pop;
   assign w_fifo_wr = w_push && !w_bypass;
   assign w_fifo_rd = w_pop && !w_bypass;
   assign w_pop_tag = w_empty ? w_grant : r_tag_mem[r_rd_ptr];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
         assign w_div_arr[gi]     = bus.req_divisor[gi*64 +: 64];
         assign bus.req_ready[gi] = w_push && (w_grant == TW'(gi));
         assign w_tag_oh[gi]      = (w_pop_tag == TW'(gi));
      end
   endgenerate

   assign bus.div_s_valid  = w_s_valid;
   assign bus.div_divisor  = w_any ? w_div_arr[w_grant] : 64'd0;
   assign bus.div_dividend = DIVIDEND;
   assign bus.outstanding  = r_outstanding;
   assign bus.busy         = !w_empty || w_any;
   assign bus.rsp_valid    = r_rsp_valid;
   assign bus.rsp_recip    = r_rsp_recip;
   assign bus.rsp_dbz      = r_rsp_dbz;
   assign bus.err_orphan   = r_err_orphan;

   assign w_unused = ^bus.div_m_data[87:16];

   always_ff @(posedge clk) begin
      if (w_fifo_wr) begin
         r_tag_mem[r_wr_ptr] <= w_grant;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_outstanding <= '0;
         r_rsp_valid   <= '0;
         r_rsp_recip   <= '0;
         r_rsp_dbz     <= 1'b0;
         r_err_orphan  <= 1'b0;
      end else begin
         if (w_push) begin
            r_rr_ptr <= (w_grant == C_LAST) ? '0 : w_grant + TW'(1);
         end
         if (w_fifo_wr) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_fifo_rd) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_fifo_wr, w_fifo_rd})
            2'b10:   r_outstanding <= r_outstanding + OW'(1);
            2'b01:   r_outstanding <= r_outstanding - OW'(1);
            default: r_outstanding <= r_outstanding;
         endcase
         r_rsp_valid <= '0;
         if (w_pop) begin
            r_rsp_valid <= w_tag_oh;
            r_rsp_recip <= {bus.div_m_data[15:0], 1'b0};
            r_rsp_dbz   <= bus.div_dbz;
         end
         if (bus.div_m_valid && !w_pop) begin
            r_err_orphan <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_recip_div_arbiter.sv
// Randomized bench for recip_div_arbiter against a queue-based model of issue order and result routing.
module tb_recip_div_arbiter;
   localparam int N   = 4;
   localparam int MO  = 8;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   recip_div_arbiter_if #(.N_REQ(N), .MAX_OUT(MO)) bus ();

   recip_div_arbiter #(.N_REQ(N), .MAX_OUT(MO), .DIVIDEND(64'd65536)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct { int req; logic [63:0] d; } issue_t;
   typedef struct { logic [63:0] d; int due; } inflight_t;

   issue_t    tagq[$];
   inflight_t divq[$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int exp_ptr = 0;

   logic [N-1:0] pend_v;
   logic [63:0]  pend_d [N];
   int gen_prob, rdy_prob;
   bit hold_div, force_orphan, all_valid, fixed_div;

   logic [N-1:0] exp_rsp_v;
   logic [16:0]  exp_recip;
   logic         exp_dbz;
   logic         exp_err;
   int           exp_out;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic logic [63:0] quot_of(input logic [63:0] d);
      return (d == 64'd0) ? {64{1'b1}} : 64'd65536 / d;
   endfunction

   function automatic logic [16:0] recip_of(input logic [63:0] d);
      logic [63:0] q;
      q = quot_of(d);
      return {q[15:0], 1'b0};
   endfunction

   function automatic logic [63:0] rand_div();
      int sel;
      sel = $urandom_range(9);
      if (sel == 0) return 64'd0;
      if (sel == 1) return {$urandom, $urandom};
      return 64'($urandom_range(1, 300));
   endfunction

   task automatic drive_req();
      bus.req_valid = pend_v;
      for (int i = 0; i < N; i++) bus.req_divisor[i*64 +: 64] = pend_d[i];
   endtask

   task automatic clear_model();
      tagq.delete();
      divq.delete();
      exp_ptr   = 0;
      exp_rsp_v = '0;
      exp_recip = '0;
      exp_dbz   = 1'b0;
      exp_err   = 1'b0;
      exp_out   = 0;
   endtask

   // One clock cycle: entered and left at a falling edge.
   task automatic do_cycle();
      int g;
      bit any, space, xfer, pop, byp;
      issue_t e;
      inflight_t dv;
      logic [63:0] q;
      logic mv, mdbz;
      logic [87:0] mdata;

      chk("rsp_valid", bus.rsp_valid, exp_rsp_v);
      chk("rsp_recip", bus.rsp_recip, exp_recip);
      chk("rsp_dbz", bus.rsp_dbz, exp_dbz);
      chk("outstanding", bus.outstanding, exp_out);
      chk("err_orphan", bus.err_orphan, exp_err);

      for (int i = 0; i < N; i++) begin
         if (!pend_v[i] && (all_valid || $urandom_range(99) < gen_prob)) begin
            pend_v[i] = 1'b1;
            pend_d[i] = fixed_div ? 64'(i + 1) : rand_div();
         end
      end
      drive_req();
      bus.div_s_ready = ($urandom_range(99) < rdy_prob);
      mv = 1'b0; mdbz = 1'b0; mdata = '0;
      if (force_orphan) begin
         mv = 1'b1;
         mdata = {24'($urandom), $urandom, $urandom};
      end else if (!hold_div && divq.size() > 0 && divq[0].due <= cyc) begin
         dv = divq.pop_front();
         q = quot_of(dv.d);
         mv = 1'b1;
         mdbz = (dv.d == 64'd0);
         mdata = {24'($urandom), q};
      end
      bus.div_m_valid = mv;
      bus.div_m_data  = mdata;
      bus.div_dbz     = mdbz;
      #1;

      any = |pend_v;
      g = 0;
      for (int k = N - 1; k >= 0; k--) if (pend_v[(exp_ptr + k) % N]) g = (exp_ptr + k) % N;
      space = (tagq.size() < MO) || (mv && tagq.size() > 0);
      xfer  = any && space && bus.div_s_ready;
      chk("div_s_valid", bus.div_s_valid, any && space);
      chk("req_ready", bus.req_ready, xfer ? (1 << g) : 0);
      chk("div_divisor", bus.div_divisor, any ? pend_d[g] : 64'd0);
      chk("div_dividend", bus.div_dividend, 64'd65536);
      chk("busy", bus.busy, any || tagq.size() > 0);

      pop = 0; byp = 0;
      if (mv) begin
         if (tagq.size() > 0) begin
            e = tagq.pop_front();
            pop = 1;
         end else if (xfer) begin
            e.req = g; e.d = pend_d[g];
            pop = 1; byp = 1;
         end else begin
            exp_err = 1'b1;
         end
      end
      if (xfer) begin
         $display("cyc %0d issue req %0d divisor %0h", cyc, g, pend_d[g]);
         if (!byp) begin
            tagq.push_back('{req: g, d: pend_d[g]});
            divq.push_back('{d: pend_d[g], due: cyc + LAT});
         end
         exp_ptr = (g + 1) % N;
         pend_v[g] = 1'b0;
      end
      exp_rsp_v = '0;
      if (pop) begin
         exp_rsp_v = N'(1 << e.req);
         exp_recip = recip_of(e.d);
         exp_dbz   = (e.d == 64'd0);
         $display("cyc %0d result req %0d recip %0h dbz %0b", cyc, e.req, exp_recip, exp_dbz);
      end
      exp_out = tagq.size();
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int n;
      all_valid = 0; gen_prob = 0; rdy_prob = 100; hold_div = 0;
      n = 0;
      while ((tagq.size() > 0 || |pend_v) && n < 200) begin
         do_cycle();
         n++;
      end
      repeat (2) do_cycle();
      chk(tag, 128'(tagq.size()) + 128'(pend_v), 128'd0);
   endtask

   initial begin
      gen_prob = 0; rdy_prob = 100; hold_div = 0; force_orphan = 0; all_valid = 0; fixed_div = 0;
      pend_v = '0;
      for (int i = 0; i < N; i++) pend_d[i] = '0;
      drive_req();
      bus.div_s_ready = 1'b0; bus.div_m_valid = 1'b0; bus.div_m_data = '0; bus.div_dbz = 1'b0;
      clear_model();
      repeat (3) @(negedge clk);
      chk("rst_outstanding", bus.outstanding, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_recip", bus.rsp_recip, 0);
      chk("rst_err", bus.err_orphan, 0);
      chk("rst_s_valid", bus.div_s_valid, 0);
      rst_n = 1'b1;

      // single request from requester 1
      pend_v[1] = 1'b1; pend_d[1] = 64'd4;
      repeat (8) do_cycle();

      // round robin with divisor i+1
      all_valid = 1; fixed_div = 1;
      repeat (12) do_cycle();
      fixed_div = 0;
      drain("drain_rr");

      // back-pressure with requesters 0 and 2
      pend_v[0] = 1'b1; pend_d[0] = 64'd7;
      pend_v[2] = 1'b1; pend_d[2] = 64'd9;
      rdy_prob = 0;
      repeat (5) do_cycle();
      drain("drain_bp");

      // fill the tag FIFO with the divider stalled
      hold_div = 1; all_valid = 1; rdy_prob = 100;
      repeat (12) do_cycle();
      chk("fill_outstanding", bus.outstanding, MO);
      chk("fill_s_valid", bus.div_s_valid, 0);
      hold_div = 0;
      do_cycle();
      hold_div = 1;
      do_cycle();
      chk("swap_outstanding", bus.outstanding, MO);
      drain("drain_fill");

      // divide by zero, then an orphan result
      pend_v[3] = 1'b1; pend_d[3] = 64'd0;
      drain("drain_dbz");
      force_orphan = 1;
      do_cycle();
      force_orphan = 0;
      repeat (3) do_cycle();
      chk("orphan_sticky", bus.err_orphan, 1);

      // randomized traffic
      gen_prob = 40; rdy_prob = 75;
      for (int i = 0; i < 400; i++) begin
         hold_div = ($urandom_range(9) == 0);
         do_cycle();
      end
      drain("drain_rand");

      // asynchronous reset with three divides in flight
      pend_v[0] = 1'b1; pend_d[0] = 64'd3;
      pend_v[1] = 1'b1; pend_d[1] = 64'd5;
      pend_v[2] = 1'b1; pend_d[2] = 64'd6;
      hold_div = 1;
      repeat (3) do_cycle();
      chk("pre_rst_outstanding", bus.outstanding, 3);
      for (int i = 0; i < N; i++) begin
         pend_v[i] = 1'b1; pend_d[i] = 64'(10 + i);
      end
      drive_req();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_outstanding", bus.outstanding, 0);
      chk("arst_rsp_valid", bus.rsp_valid, 0);
      chk("arst_s_valid", bus.div_s_valid, 0);
      chk("arst_req_ready", bus.req_ready, 0);
      chk("arst_err", bus.err_orphan, 0);
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      hold_div = 0;
      do_cycle();
      repeat (10) do_cycle();
      drain("drain_post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
